afc_cal_sequencer: RTL
======================

// Module: afc_cal_sequencer
// PURPOSE
//  Upstream controller for the 4-channel AFC block. It calibrates each channel selected in a mask, one after another.
//  For each channel it drives calChSel, calSource, overridecontrol and AFCstart, then waits for the AFCbusy handshake.
//  It captures the resulting 6-bit calControlCode into that channel's overridecontrol_valN register.
//  After the sequence, overridecontrol is held high so every channel runs on its stored code.
// PARAMETERS
//  SETTLE_CYC   16     cycles between the calChSel change and the AFCstart pulse (mux/divider settling)
//  START_CYC    4      AFCstart pulse width, in cycles
//  TIMEOUT_CYC  65535  max cycles from the AFCstart fall to the AFCbusy fall before the channel is aborted (16-bit counter)
//  RANGE_LO     1      lowest acceptable code (used only with AFC_RANGE_CHECK_EN)
//  RANGE_HI     62     highest acceptable code (used only with AFC_RANGE_CHECK_EN)
// PORTS
//  extCLK40              in   1  40 MHz clock; the only clock
//  reset                 in   1  synchronous, active-low reset
//  calStart              in   1  level; sampled high in IDLE starts a sequence
//  calAbort              in   1  level; returns the FSM to IDLE from any state
//  chMask                in   4  channels to calibrate; bit0 = ch1; sampled at start
//  calSourceCfg          in   1  0 = extCLK40 reference, 1 = data reference; sampled at start
//  AFCbusy               in   1  AFC busy flag; passed through a 2-flop synchronizer internally
//  calControlCode        in   6  AFC binary result; valid when AFCbusy is low
//  AFCstart              out  1  start pulse to the AFC
//  calChSel              out  2  channel under calibration (0..3)
//  calSource             out  1  registered copy of calSourceCfg
//  overridecontrol       out  1  0 while a sequence runs, 1 otherwise
//  overridecontrol_val1..4 out 6  stored per-channel codes
//  seqBusy               out  1  high whenever the FSM is not IDLE
//  seqDone               out  1  high from normal completion until the next start or reset
//  chTimeout             out  4  sticky per-channel timeout flags
//  chRangeErr            out  4  sticky per-channel out-of-range flags (0 without the macro)
// BEHAVIOUR
//  Reset values: AFCstart=0, calChSel=0, calSource=0, overridecontrol=1, all vals=6'd32, seqBusy=0, seqDone=0, all flags=0.
//  FSM states: IDLE, SETTLE, START, WAIT_HI, WAIT_LO, CAPTURE, NEXT. All outputs are registered.
//  IDLE: on calStart=1:
//   - latch chMask and calSourceCfg; clear seqDone; clear the flags of the masked channels.
//   - if the mask is nonzero: ch = lowest set bit, overridecontrol=0, go to SETTLE.
//   - if the mask is zero: seqDone=1 on the next cycle and stay in IDLE.
//  SETTLE: calChSel=ch; count SETTLE_CYC cycles, then go to START.
//  START: AFCstart=1 for exactly START_CYC cycles, then go to WAIT_HI. The timer is cleared on entry to WAIT_HI.
//  WAIT_HI: wait for synced AFCbusy=1, then go to WAIT_LO.
//  WAIT_LO: wait for synced AFCbusy=0, then go to CAPTURE.
//  Timeout: in WAIT_HI and WAIT_LO the timer increments every cycle. When it reaches TIMEOUT_CYC, set chTimeout[ch], leave val unchanged, go to NEXT.
//  CAPTURE: valN <= calControlCode (one cycle), then go to NEXT.
//  NEXT: find the next set mask bit above ch. If found, go to SETTLE with the new ch. If none, set overridecontrol=1, seqDone=1, go to IDLE.
//  Latency: from the calChSel change to the AFCstart rise is SETTLE_CYC+1 cycles.
//  Busy handling:
//   - calStart while seqBusy=1 is ignored.
//   - calAbort wins over calStart and over every state transition in the same cycle.
//  Abort: on calAbort in any non-IDLE state, go to IDLE next cycle with AFCstart=0, overridecontrol=1, seqDone=0. Captured vals and flags are kept.
//  Reset asserted mid-sequence restores all reset values, including the vals.
//  AFCbusy already high in START does not advance the FSM; it is honoured only after entry to WAIT_HI.
// CONFIGURATION
//  AFC_RANGE_CHECK_EN defined:
//   - in CAPTURE, a code <RANGE_LO or >RANGE_HI sets chRangeErr[ch] and is still stored.
//  AFC_RANGE_CHECK_EN undefined:
//   - chRangeErr is tied to 4'b0 and no comparators are built.
// TESTING
//  1. mask=4'b1111, AFC model returns codes 10,20,30,40. Expect vals 10/20/30/40, calChSel 0->1->2->3, seqDone=1, overridecontrol=1 at end.
//  2. mask=4'b0101. Expect only ch1/ch3 calibrated; val2 and val4 stay 32; exactly 2 AFCstart pulses, each 4 cycles wide.
//  3. AFCbusy held low on ch2 with TIMEOUT_CYC=100. Expect chTimeout=4'b0010 101 cycles after WAIT_HI entry, val2=32, sequence continues to ch3.
//  4. calAbort during WAIT_LO of ch2. Expect IDLE next cycle, val1 kept, overridecontrol=1, seqDone=0; a new calStart restarts from ch1.
//  5. mask=0 + calStart. Expect seqDone=1 next cycle and no AFCstart pulse.
//  6. With the macro, code 63 on ch4 -> chRangeErr=4'b1000, val4=63. Without the macro, chRangeErr stays 0.

Source files
------------

// File: rtl/afc_cal_sequencer.sv
// Calibrates each masked AFC channel in turn, captures its 6-bit code and then hands the AFC its stored codes.
// Optional feature macro AFC_RANGE_CHECK_EN adds sticky per-channel out-of-range flags on captured codes.
module afc_cal_sequencer #(
    parameter int SETTLE_CYC  = 16,
    parameter int START_CYC   = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int RANGE_LO    = 1,
    parameter int RANGE_HI    = 62
) (
    input  logic       extCLK40,
    input  logic       reset,
    input  logic       calStart,
    input  logic       calAbort,
    input  logic [3:0] chMask,
    input  logic       calSourceCfg,
    input  logic       AFCbusy,
    input  logic [5:0] calControlCode,
    output logic       AFCstart,
    output logic [1:0] calChSel,
    output logic       calSource,
    output logic       overridecontrol,
    output logic [5:0] overridecontrol_val1,
    output logic [5:0] overridecontrol_val2,
    output logic [5:0] overridecontrol_val3,
    output logic [5:0] overridecontrol_val4,
    output logic       seqBusy,
    output logic       seqDone,
    output logic [3:0] chTimeout,
    output logic [3:0] chRangeErr
);
    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT_HI, WAIT_LO, CAPTURE, NEXT} state_t;

    localparam logic [15:0] SETTLE_LIM  = 16'(SETTLE_CYC);
    localparam logic [15:0] START_LIM   = 16'(START_CYC - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    state_t          state;
    logic [15:0]     timer;
    logic [3:0]      maskLat;
    logic [3:0][5:0] vals;
    logic            busyMeta, busySync;
    logic [1:0]      firstCh, nextCh;
    logic            nextFound;

    assign overridecontrol_val1 = vals[0];
    assign overridecontrol_val2 = vals[1];
    assign overridecontrol_val3 = vals[2];
    assign overridecontrol_val4 = vals[3];

    // calChSel doubles as the current-channel register
    always_comb begin
        firstCh   = 2'd0;
        nextCh    = 2'd0;
        nextFound = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (chMask[i])
                firstCh = 2'(i);
            if (maskLat[i] && (2'(i) > calChSel)) begin
                nextFound = 1'b1;
                nextCh    = 2'(i);
            end
        end
    end

`ifdef AFC_RANGE_CHECK_EN
    localparam logic [5:0] CODE_LO = 6'(RANGE_LO);
    localparam logic [5:0] CODE_HI = 6'(RANGE_HI);
    logic codeBad;
    assign codeBad = (calControlCode < CODE_LO) || (calControlCode > CODE_HI);
`else
    assign chRangeErr = 4'b0;
`endif

    always_ff @(posedge extCLK40) begin
        if (!reset) begin
            state           <= IDLE;
            timer           <= '0;
            maskLat         <= '0;
            vals            <= {4{6'd32}};
            busyMeta        <= 1'b0;
            busySync        <= 1'b0;
            AFCstart        <= 1'b0;
            calChSel        <= 2'd0;
            calSource       <= 1'b0;
            overridecontrol <= 1'b1;
            seqBusy         <= 1'b0;
            seqDone         <= 1'b0;
            chTimeout       <= '0;
`ifdef AFC_RANGE_CHECK_EN
            chRangeErr      <= '0;
`endif
        end else begin
            busyMeta <= AFCbusy;
            busySync <= busyMeta;
            if (calAbort && state != IDLE) begin
                state           <= IDLE;
                AFCstart        <= 1'b0;
                overridecontrol <= 1'b1;
                seqBusy         <= 1'b0;
                seqDone         <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (calStart && !calAbort) begin
                        maskLat   <= chMask;
                        calSource <= calSourceCfg;
                        seqDone   <= (chMask == 4'b0);
                        chTimeout <= chTimeout & ~chMask;
`ifdef AFC_RANGE_CHECK_EN
                        chRangeErr <= chRangeErr & ~chMask;
`endif
                        if (chMask != 4'b0) begin
                            calChSel        <= firstCh;
                            overridecontrol <= 1'b0;
                            seqBusy         <= 1'b1;
                            timer           <= '0;
                            state           <= SETTLE;
                        end
                    end
                    // SETTLE spans SETTLE_CYC+1 cycles so AFCstart rises SETTLE_CYC+1 after calChSel moves
                    SETTLE: if (timer == SETTLE_LIM) begin
                        timer    <= '0;
                        AFCstart <= 1'b1;
                        state    <= START;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                    START: if (timer == START_LIM) begin
                        timer    <= '0;
                        AFCstart <= 1'b0;
                        state    <= WAIT_HI;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                    WAIT_HI, WAIT_LO: if (timer == TIMEOUT_LIM) begin
                        chTimeout[calChSel] <= 1'b1;
                        state               <= NEXT;
                    end else begin
                        timer <= timer + 16'd1;
                        if (state == WAIT_HI && busySync)
                            state <= WAIT_LO;
                        else if (state == WAIT_LO && !busySync)
                            state <= CAPTURE;
                    end
                    CAPTURE: begin
                        vals[calChSel] <= calControlCode;
`ifdef AFC_RANGE_CHECK_EN
                        if (codeBad)
                            chRangeErr[calChSel] <= 1'b1;
`endif
                        state <= NEXT;
                    end
                    NEXT: if (nextFound) begin
                        calChSel <= nextCh;
                        timer    <= '0;
                        state    <= SETTLE;
                    end else begin
                        overridecontrol <= 1'b1;
                        seqDone         <= 1'b1;
                        seqBusy         <= 1'b0;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
